// File: rtl/muldiv_sequencer_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer.
package muldiv_sequencer_pkg;

   localparam int unsigned MD_DATA_W = 32;
   localparam int unsigned MD_CNT_W  = 6;

   typedef enum logic [1:0] {
      MD_MULT  = 2'b00,
      MD_MULTU = 2'b01,
      MD_DIV   = 2'b10,
      MD_DIVU  = 2'b11
   } md_op_e;

   typedef enum logic [2:0] {
      StIdle,
      StMul,
      StDiv,
      StSign,
      StDone
   } md_state_e;

endpackage

// File: rtl/muldiv_sequencer_if.sv
// EX-stage request, stall/done and HI/LO bundle for the mul/div sequencer.
interface muldiv_sequencer_if #(
   parameter int unsigned DATA_W = muldiv_sequencer_pkg::MD_DATA_W
);
   logic              start;
   logic [1:0]        op;
   logic [DATA_W-1:0] src_a;
   logic [DATA_W-1:0] src_b;
   logic              flush;
   logic              hi_we;
   logic              lo_we;
   logic [DATA_W-1:0] wdata;
   logic              stall_ex;
   logic              done;
   logic              busy;
   logic [DATA_W-1:0] hi;
   logic [DATA_W-1:0] lo;

   modport master (
      output start, op, src_a, src_b, flush, hi_we, lo_we, wdata,
      input  stall_ex, done, busy, hi, lo
   );

   modport slave (
      input  start, op, src_a, src_b, flush, hi_we, lo_we, wdata,
      output stall_ex, done, busy, hi, lo
   );
endinterface

// File: rtl/muldiv_iter_core.sv
// Unsigned 1-bit-per-cycle datapath: shift-add multiply or restoring divide.
// Multiply: {hi,lo} accumulates the product, lo starts as the multiplier.
// Divide: hi is the partial remainder, lo shifts the dividend out and quotient in.
module muldiv_iter_core #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned CNT_W  = 6
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              load_i,
   input  logic              step_i,
   input  logic              is_div_i,
   input  logic [DATA_W-1:0] opa_i,
   input  logic [DATA_W-1:0] opb_i,
   output logic [DATA_W-1:0] hi_o,
   output logic [DATA_W-1:0] lo_o,
   output logic              last_o
);

   logic [DATA_W-1:0] hi_q, hi_d, lo_q, lo_d, m_q, m_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W:0]   mul_add;
   logic [DATA_W:0]   div_sh;
   logic [DATA_W-1:0] div_diff;
   logic              div_ok;

   // Next-state for one iteration, or a fresh load on accept.
   always_comb begin
      mul_add  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
      div_sh   = {hi_q, lo_q[DATA_W-1]};
      div_ok   = (div_sh >= {1'b0, m_q});
      // Only used when div_ok, so the true difference fits in DATA_W bits.
      div_diff = div_sh[DATA_W-1:0] - m_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      m_d      = m_q;
      cnt_d    = cnt_q;
      if (load_i) begin
         hi_d  = '0;
         lo_d  = opa_i;
         m_d   = opb_i;
         cnt_d = '0;
      end else if (step_i) begin
         cnt_d = cnt_q + 1'b1;
         if (is_div_i) begin
            hi_d = div_ok ? div_diff : div_sh[DATA_W-1:0];
            lo_d = {lo_q[DATA_W-2:0], div_ok};
         end else begin
            {hi_d, lo_d} = {mul_add, lo_q[DATA_W-1:1]};
         end
      end
   end

   // Datapath registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         hi_q  <= '0;
         lo_q  <= '0;
         m_q   <= '0;
         cnt_q <= '0;
      end else begin
         hi_q  <= hi_d;
         lo_q  <= lo_d;
         m_q   <= m_d;
         cnt_q <= cnt_d;
      end
   end

   assign hi_o   = hi_q;
   assign lo_o   = lo_q;
   assign last_o = (cnt_q == CNT_W'(DATA_W - 1));

endmodule

// File: rtl/muldiv_sequencer.sv
// MIPS EX-stage HI/LO mul/div sequencer: FSM, sign handling and HI/LO registers.
module muldiv_sequencer
   import muldiv_sequencer_pkg::*;
#(
   parameter int unsigned DATA_W = MD_DATA_W,
   parameter int unsigned CNT_W  = MD_CNT_W
) (
   input  logic          clk,
   input  logic          resetn,
   muldiv_sequencer_if.slave bus
);

   md_state_e         state_q, state_d;
   logic              is_div_q, is_div_d, neg_res_q, neg_res_d, neg_rem_q, neg_rem_d;
   logic [DATA_W-1:0] hi_q, hi_d, lo_q, lo_d;
   logic              accept, signed_op, stall, last;
   logic [DATA_W-1:0] abs_a, abs_b, core_hi, core_lo;
   logic [2*DATA_W-1:0] prod;

   assign accept    = (state_q == StIdle) && bus.start && !bus.flush;
   assign signed_op = ~bus.op[0];
   assign abs_a     = (signed_op && bus.src_a[DATA_W-1]) ? -bus.src_a : bus.src_a;
   assign abs_b     = (signed_op && bus.src_b[DATA_W-1]) ? -bus.src_b : bus.src_b;

   muldiv_iter_core #(
      .DATA_W (DATA_W),
      .CNT_W  (CNT_W)
   ) u_core (
      .clk_i    (clk),
      .rst_ni   (resetn),
      .load_i   (accept),
      .step_i   ((state_q == StMul) || (state_q == StDiv)),
      .is_div_i (is_div_q),
      .opa_i    (bus.op[1] ? abs_a : abs_b),
      .opb_i    (bus.op[1] ? abs_b : abs_a),
      .hi_o     (core_hi),
      .lo_o     (core_lo),
      .last_o   (last)
   );

   // FSM next state and stall/done; flush always returns to idle.
   always_comb begin
      state_d  = state_q;
      stall    = 1'b0;
      bus.done = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               state_d = bus.op[1] ? StDiv : StMul;
               stall   = 1'b1;
            end
         end
         StMul, StDiv: begin
            stall = 1'b1;
            if (last) state_d = StSign;
         end
         StSign: begin
            stall   = 1'b1;
            state_d = StDone;
         end
         StDone: begin
            bus.done = 1'b1;
            state_d  = StIdle;
         end
         default: state_d = StIdle;
      endcase
      if (bus.flush) state_d = StIdle;
   end

   // Operation flags captured on accept; HI/LO from MTHI/MTLO or the signed-fixed result.
   always_comb begin
      is_div_d  = is_div_q;
      neg_res_d = neg_res_q;
      neg_rem_d = neg_rem_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      prod      = {core_hi, core_lo};
      if (accept) begin
         is_div_d  = bus.op[1];
         neg_res_d = signed_op && (bus.src_a[DATA_W-1] ^ bus.src_b[DATA_W-1]);
         neg_rem_d = signed_op && bus.src_a[DATA_W-1];
      end
      if (state_q == StIdle) begin
         if (bus.hi_we) hi_d = bus.wdata;
         if (bus.lo_we) lo_d = bus.wdata;
      end else if ((state_q == StSign) && !bus.flush) begin
         if (is_div_q) begin
            lo_d = neg_res_q ? -core_lo : core_lo;
            hi_d = neg_rem_q ? -core_hi : core_hi;
         end else begin
            {hi_d, lo_d} = neg_res_q ? -prod : prod;
         end
      end
   end

   // State, flags and architectural HI/LO.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q   <= StIdle;
         is_div_q  <= 1'b0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
      end else begin
         state_q   <= state_d;
         is_div_q  <= is_div_d;
         neg_res_q <= neg_res_d;
         neg_rem_q <= neg_rem_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
      end
   end

   // Accept-cycle stall is combinational on start, so mask it while reset is held.
   assign bus.stall_ex = stall && resetn;
   assign bus.busy     = (state_q != StIdle);
   assign bus.hi       = hi_q;
   assign bus.lo       = lo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: vector table plus corner sequences.
module tb_muldiv_sequencer;
   import muldiv_sequencer_pkg::*;

   typedef struct {
      string       name;
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [63:0] exp;  // {hi, lo}
   } vec_t;

   logic clk = 1'b0;
   logic resetn = 1'b0;
   int   n_vec = 0;
   int   n_bad = 0;
   logic [63:0] sb[$];
   vec_t vecs[12];

   muldiv_sequencer_if #(.DATA_W(32)) bus ();

   muldiv_sequencer #(
      .DATA_W (32),
      .CNT_W  (6)
   ) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Starts an op at the next negedge (cycle 0) and checks the accept-cycle stall.
   task automatic issue(input string name, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input bit push, input logic [63:0] exp);
      @(negedge clk); #1;
      bus.start = 1'b1;
      bus.op    = op;
      bus.src_a = a;
      bus.src_b = b;
      if (push) sb.push_back(exp);
      #1;
      check({name, " accept stall"}, 64'(bus.stall_ex), 64'd1);
   endtask

   // Waits (bounded) for done; k0 is the cycle index the caller has reached.
   task automatic wait_done(input int k0, output int lat, output bit stall_ok);
      lat = -1;
      stall_ok = 1'b1;
      for (int k = k0 + 1; k <= k0 + 80; k++) begin
         @(negedge clk); #1;
         if (bus.done) begin
            lat = k;
            break;
         end
         if (!bus.stall_ex || !bus.busy) stall_ok = 1'b0;
      end
   endtask

   task automatic finish_op(input string name, input int lat, input bit stall_ok);
      logic [63:0] exp;
      check({name, " latency"}, 64'(lat), 64'd34);
      check({name, " stall"}, 64'(stall_ok), 64'd1);
      exp = (sb.size() > 0) ? sb.pop_front() : 64'hx;
      if (lat > 0) begin
         check({name, " hi/lo"}, {bus.hi, bus.lo}, exp);
         check({name, " done stall"}, 64'(bus.stall_ex), 64'd0);
      end
   endtask

   initial begin
      int  lat;
      bit  sok;
      int  dones;

      vecs[0]  = '{"mult -3*5",     MD_MULT,  32'hFFFFFFFD, 32'd5,        64'hFFFFFFFF_FFFFFFF1};
      vecs[1]  = '{"divu 100/7",    MD_DIVU,  32'd100,      32'd7,        64'h00000002_0000000E};
      vecs[2]  = '{"div -7/2",      MD_DIV,   32'hFFFFFFF9, 32'd2,        64'hFFFFFFFF_FFFFFFFD};
      vecs[3]  = '{"divu 1234/0",   MD_DIVU,  32'd1234,     32'd0,        64'h000004D2_FFFFFFFF};
      vecs[4]  = '{"multu max*max", MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001};
      vecs[5]  = '{"div min/-1",    MD_DIV,   32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000};
      vecs[6]  = '{"mult min*min",  MD_MULT,  32'h80000000, 32'h80000000, 64'h40000000_00000000};
      vecs[7]  = '{"div 7/-2",      MD_DIV,   32'd7,        32'hFFFFFFFE, 64'h00000001_FFFFFFFD};
      vecs[8]  = '{"multu x*16",    MD_MULTU, 32'h12345678, 32'd16,       64'h00000001_23456780};
      vecs[9]  = '{"div -7/0",      MD_DIV,   32'hFFFFFFF9, 32'd0,        64'hFFFFFFF9_00000001};
      vecs[10] = '{"mult 7*-6",     MD_MULT,  32'd7,        32'hFFFFFFFA, 64'hFFFFFFFF_FFFFFFD6};
      vecs[11] = '{"divu max/1",    MD_DIVU,  32'hFFFFFFFF, 32'd1,        64'h00000000_FFFFFFFF};

      bus.start = 1'b1;  // must not leak through stall_ex during reset
      bus.op    = 2'b00;
      bus.src_a = '0;
      bus.src_b = '0;
      bus.flush = 1'b0;
      bus.hi_we = 1'b0;
      bus.lo_we = 1'b0;
      bus.wdata = '0;

      repeat (2) @(negedge clk);
      #1;
      check("reset hi/lo", {bus.hi, bus.lo}, 64'd0);
      check("reset busy", 64'(bus.busy), 64'd0);
      check("reset done", 64'(bus.done), 64'd0);
      check("reset stall", 64'(bus.stall_ex), 64'd0);
      bus.start = 1'b0;
      resetn = 1'b1;

      // Table-driven operations.
      for (int i = 0; i < 12; i++) begin
         issue(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, 1'b1, vecs[i].exp);
         wait_done(0, lat, sok);
         bus.start = 1'b0;
         finish_op(vecs[i].name, lat, sok);
      end
      @(negedge clk); #1;
      check("idle after done", 64'(bus.busy), 64'd0);

      // Flush at cycle 10 of a MULTU: no done, HI/LO keep the last result.
      issue("flush", MD_MULTU, 32'd5, 32'd6, 1'b0, 64'd0);
      dones = 0;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk); #1;
         if (bus.done) dones++;
      end
      bus.flush = 1'b1;
      bus.start = 1'b0;
      @(negedge clk); #1;
      bus.flush = 1'b0;
      check("flush busy", 64'(bus.busy), 64'd0);
      check("flush hi/lo", {bus.hi, bus.lo}, vecs[11].exp);
      for (int k = 0; k < 40; k++) begin
         @(negedge clk); #1;
         if (bus.done) dones++;
      end
      check("flush no done", 64'(dones), 64'd0);

      // start held through DONE: one pulse, idle at 35, re-accepted at 35.
      issue("held", MD_MULTU, 32'd3, 32'd4, 1'b1, 64'd12);
      wait_done(0, lat, sok);
      finish_op("held first", lat, sok);
      @(negedge clk); #1;
      check("held idle 35", 64'(bus.busy), 64'd0);
      check("held done 35", 64'(bus.done), 64'd0);
      check("held reaccept", 64'(bus.stall_ex), 64'd1);
      sb.push_back(64'd12);
      wait_done(0, lat, sok);
      bus.start = 1'b0;
      finish_op("held second", lat, sok);

      // Asynchronous reset at cycle 15 of a DIV.
      issue("reset mid", MD_DIV, 32'd1000, 32'd3, 1'b0, 64'd0);
      repeat (15) @(negedge clk);
      #1;
      resetn = 1'b0;
      #1;
      check("midreset hi/lo", {bus.hi, bus.lo}, 64'd0);
      check("midreset busy", 64'(bus.busy), 64'd0);
      check("midreset stall", 64'(bus.stall_ex), 64'd0);
      bus.start = 1'b0;
      @(negedge clk); #1;
      resetn = 1'b1;

      // MTLO/MTHI in idle, then MTLO ignored while busy.
      @(negedge clk); #1;
      bus.lo_we = 1'b1;
      bus.wdata = 32'hABCD0000;
      @(negedge clk); #1;
      bus.lo_we = 1'b0;
      check("mtlo idle", 64'(bus.lo), 64'hABCD0000);
      bus.hi_we = 1'b1;
      bus.wdata = 32'h5A5A5A5A;
      @(negedge clk); #1;
      bus.hi_we = 1'b0;
      check("mthi idle", 64'(bus.hi), 64'h5A5A5A5A);

      issue("mtlo busy", MD_MULTU, 32'd2, 32'd3, 1'b1, 64'd6);
      repeat (5) @(negedge clk);
      #1;
      bus.lo_we = 1'b1;
      bus.wdata = 32'h12345678;
      @(negedge clk); #1;
      bus.lo_we = 1'b0;
      check("mtlo busy ignored", 64'(bus.lo), 64'hABCD0000);
      wait_done(6, lat, sok);
      bus.start = 1'b0;
      finish_op("mtlo busy", lat, sok);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Multi-cycle HI/LO multiply/divide sequencer for the EX stage of the 5-stage MIPS pipeline.
- Takes MULT/MULTU/DIV/DIVU from EX and runs a 1-bit-per-cycle shift-add multiplier or restoring divider.
- Drives the EX-stall and done pair consumed by the hazard/stall control, and owns the architectural HI/LO registers, including MTHI/MTLO writes.
- On an exception clear, aborts the operation.

Parameters:
- DATA_W, 32, operand/HI/LO width.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > DATA_W.

Ports:
- clk  in  1  system clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- start  in  1  EX holds a mul/div instruction; level, held while stalled.
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start.
- src_a  in  DATA_W  rs value (multiplicand/dividend); sampled at accept.
- src_b  in  DATA_W  rt value (multiplier/divisor); sampled at accept.
- flush  in  1  exception clear; synchronous abort.
- hi_we  in  1  MTHI write enable.
- lo_we  in  1  MTLO write enable.
- wdata  in  DATA_W  MTHI/MTLO data.
- stall_ex  out  1  EX must hold.
- done  out  1  one-cycle pulse; HI/LO updated this cycle.
- busy  out  1  state != IDLE.
- hi  out  DATA_W  HI register.
- lo  out  DATA_W  LO register.

Behaviour:
- Reset (resetn=0, async): state=IDLE, hi=0, lo=0, counter=0, internal shift regs=0. While in reset: done=0, busy=0, stall_ex=0. Reset mid-operation discards the operation.
- States: IDLE, MUL, DIV, SIGN, DONE.
- IDLE:
  - start=1 and flush=0: latch op, |src_a| and |src_b| (signed ops only; unsigned ops pass raw), and the result sign flags; counter=0.
  - Next state is MUL for op[1]=0, DIV for op[1]=1.
  - stall_ex=start&~flush, combinational, so the accept cycle already stalls.
- MUL: 64-bit accumulator, shift-add one multiplier bit per cycle; after DATA_W iterations (counter==DATA_W-1) go to SIGN.
- DIV: restoring divide, one quotient bit per cycle (remainder shift, trial subtract, keep if non-negative); after DATA_W iterations go to SIGN.
- SIGN:
  - Multiply: negate the 64-bit product if signs differ.
  - Divide: negate the quotient if signs differ; the remainder takes the dividend's sign.
  - Next state DONE.
- DONE: hi/lo loaded at the clock edge entering DONE; done=1, stall_ex=0; next state IDLE unconditionally.
  - start is still high in DONE (the instruction is leaving EX) and must not be re-accepted.
- stall_ex=1 in MUL, DIV, SIGN; 0 in IDLE (except on accept) and in DONE.
- Latency: accept at cycle 0, iterations cycles 1..32, SIGN cycle 33, DONE cycle 34 (done=1). Fixed for all ops and operands.
- Divide by zero: no trap, full latency.
  - Unsigned: lo=FFFFFFFF, hi=src_a.
  - Signed: same raw values, then sign fixup.
- -2^31 / -1: lo=80000000, hi=0 (wrap).
- flush: in any state, next state=IDLE; hi/lo unchanged; no done. flush has priority over start in IDLE.
- MTHI/MTLO: hi_we/lo_we write hi/lo in IDLE only; ignored while busy. In the DONE cycle the operation result wins.

Decomposition:
- Shared package holds:
  - op encodings MD_MULT=2'b00, MD_MULTU=2'b01, MD_DIV=2'b10, MD_DIVU=2'b11;
  - state localparams;
  - the DATA_W default, shared with the ALU/hazard control.
- One natural sub-module, muldiv_iter_core: the shift-add/restoring datapath with start/step/last controls. The FSM, sign handling and HI/LO stay in the top.

Test Plan:
- MULT src_a=FFFFFFFD(-3), src_b=5 -> stall_ex=1 cycles 0..33, done at cycle 34, hi=FFFFFFFF, lo=FFFFFFF1.
- DIVU 100/7 -> lo=0000000E, hi=00000002 at done; DIV FFFFFFF9(-7)/2 -> lo=FFFFFFFD, hi=FFFFFFFF.
- DIVU 1234/0 -> lo=FFFFFFFF, hi=000004D2, done at cycle 34, no hang.
- MULTU, then flush at cycle 10 -> IDLE next cycle, done never asserts, hi/lo keep prior values.
- start held high through DONE -> exactly one done pulse, state IDLE at cycle 35; a new start at cycle 35 is accepted.
- resetn low at cycle 15 of a DIV -> hi=lo=0, busy=0 immediately; MTLO wdata=ABCD0000 in IDLE -> lo=ABCD0000; MTLO while busy -> lo unchanged.
